// File: rtl/rca6_share_ctrl_pkg.sv
// rtl/rca6_share_ctrl_pkg.sv - shared encodings for the rca6 adder-sharing controller
package rca6_share_ctrl_pkg;

  localparam int AW_DEF = 6;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_ADD12 = 2'b10;
  localparam logic [1:0] OP_SUB12 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic op_is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SUB12);
  endfunction

  function automatic logic op_is_wide(input logic [1:0] op);
    return (op == OP_ADD12) || (op == OP_SUB12);
  endfunction

endpackage

// File: rtl/rca6_share_ctrl_rr_arb2.sv
// rtl/rca6_share_ctrl_rr_arb2.sv - two-requester round-robin arbiter
// The pointer moves to the other requester only when i_en is high and a grant is made.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  logic r_prio;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_en && (|i_req)) begin
      r_prio <= o_grant[0];
    end
  end

endmodule

// File: rtl/rca6_share_ctrl.sv
// rtl/rca6_share_ctrl.sv - time-shares one external AW-bit ripple adder between two requesters
// 2*AW ops run as a low pass then a high pass chained through the registered carry.
module rca6_share_ctrl
  import rca6_share_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_op0,
  input  logic [1:0]      req_op1,
  input  logic [2*AW-1:0] req_a0,
  input  logic [2*AW-1:0] req_b0,
  input  logic [2*AW-1:0] req_a1,
  input  logic [2*AW-1:0] req_b1,
  output logic [AW-1:0]   add_a,
  output logic [AW-1:0]   add_b,
  output logic            add_cin,
  input  logic [AW-1:0]   add_sum,
  input  logic            add_cout,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [2*AW-1:0] resp_result,
  output logic            resp_cout,
  output logic            resp_ovf
);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_op;
  logic [2*AW-1:0] r_a;
  logic [2*AW-1:0] r_b;
  logic [2*AW-1:0] r_result;
  logic            r_id;
  logic            r_cout;
  logic            r_ovf;

  logic [1:0]      w_grant;
  logic            w_accept_en;
  logic            w_accept;
  logic            w_is_sub;
  logic            w_is_wide;
  logic            w_ovf;

  // Gating with rst_n keeps req_ready low while reset is held, even though the FSM sits in IDLE.
  assign w_accept_en = rst_n && (r_state == S_IDLE);
  assign w_accept    = w_accept_en && (|req_valid);
  assign req_ready   = w_accept_en ? w_grant : 2'b00;

  assign w_is_sub  = op_is_sub(r_op);
  assign w_is_wide = op_is_wide(r_op);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req_valid),
    .i_en    (w_accept_en),
    .o_grant (w_grant)
  );

  always_comb begin
    w_next  = r_state;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) w_next = S_LO;
      end
      S_LO: begin
        add_a   = r_a[AW-1:0];
        add_b   = r_b[AW-1:0] ^ {AW{w_is_sub}};
        add_cin = w_is_sub;
        w_next  = w_is_wide ? S_HI : S_DONE;
      end
      S_HI: begin
        add_a   = r_a[2*AW-1:AW];
        add_b   = r_b[2*AW-1:AW] ^ {AW{w_is_sub}};
        add_cin = r_cout;
        w_next  = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Signed overflow of whichever pass is currently on the adder.
  assign w_ovf = (add_a[AW-1] == add_b[AW-1]) && (add_sum[AW-1] != add_a[AW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id <= w_grant[1];
            r_op <= w_grant[1] ? req_op1 : req_op0;
            r_a  <= w_grant[1] ? req_a1 : req_a0;
            r_b  <= w_grant[1] ? req_b1 : req_b0;
          end
        end
        S_LO: begin
          r_result <= {{AW{1'b0}}, add_sum};
          r_cout   <= add_cout;
          r_ovf    <= w_ovf;
        end
        S_HI: begin
          r_result[2*AW-1:AW] <= add_sum;
          r_cout              <= add_cout;
          r_ovf               <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid  = (r_state == S_DONE);
  assign resp_id     = r_id;
  assign resp_result = r_result;
  assign resp_cout   = r_cout;
  assign resp_ovf    = r_ovf;

endmodule

// File: doc/rca6_share_ctrl.md
Name: rca6_share_ctrl

Overview:
Controller that time-shares the team's single 6-bit ripple-carry adder between two requesters. It accepts ADD/SUB operations at 6-bit width, or at 12-bit width executed as two carry-chained adder passes. It drives the adder's operand and carry-in ports and registers the result. It sits between the ALU front-end request queues and the shared adder instance.

Parameters:
AW, 6, adder width; must equal the shared adder width; double-width ops are 2*AW.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept pulse
req_op0  in  2  requester 0 op: 00 ADD, 01 SUB, 10 ADD12, 11 SUB12
req_op1  in  2  requester 1 op, same encoding
req_a0, req_b0  in  2*AW each  requester 0 operands; 6-bit ops use the low AW bits
req_a1, req_b1  in  2*AW each  requester 1 operands
add_a  out  AW  adder operand A
add_b  out  AW  adder operand B (already inverted for SUB)
add_cin  out  1  adder carry-in
add_sum  in  AW  adder sum (combinational from add_a/add_b/add_cin)
add_cout  in  1  adder carry-out
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_id  out  1  requester that owns the result
resp_result  out  2*AW  result; upper AW bits are 0 for 6-bit ops
resp_cout  out  1  final carry-out (SUB: 1 = no borrow)
resp_ovf  out  1  signed overflow at op width

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready = 0, resp_* = 0, add_* = 0, rr pointer favours requester 0. Reset mid-operation aborts with no response.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If any req_valid is high, the round-robin grant picks requester g.
  - req_ready[g] = 1 for exactly that cycle (combinational from state and valid).
  - On the edge: latch op, operands and id; the rr pointer then prefers the other requester.
  - Transition to LO.
- LO:
  - add_a = a[AW-1:0]; add_b = b[AW-1:0], or its inverse for SUB; add_cin = is_sub.
  - On the edge: register sum into result[AW-1:0] and cout into the carry register.
  - 6-bit op: overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is b after inversion; go to DONE.
  - 12-bit op: go to HI.
- HI:
  - add_a = a[2AW-1:AW]; add_b = high half of b, inverted for SUB; add_cin = registered carry.
  - On the edge: register the high sum, final cout and 12-bit overflow (same formula on the high-half MSBs); go to DONE.
- DONE:
  - resp_valid = 1; resp_* are held stable while resp_ready is low.
  - When resp_valid && resp_ready: go to IDLE, clear resp_valid.
  - No new request is accepted in the handoff cycle.
- add_* outputs are 0 in IDLE and DONE.
- Latency from the accept edge to resp_valid: 2 cycles for 6-bit ops, 3 cycles for 12-bit ops.
- Throughput: one op in flight; req_ready stays 0 outside IDLE.
- Arbitration:
  - Both valid: grant the rr-preferred requester.
  - Only one valid: grant it regardless of the pointer.
  - The pointer updates only on a grant.
- Requesters must hold operands stable until their req_ready pulse. The controller samples them only on the accept edge.
- Arithmetic is modulo 2^width; no saturation.

Decomposition:
- Shared package:
  - op encoding constants OP_ADD/OP_SUB/OP_ADD12/OP_SUB12;
  - state encoding S_IDLE/S_LO/S_HI/S_DONE;
  - default AW.
- One sub-module: rr_arb2, a 2-requester round-robin arbiter with grant and pointer-update enable.
- The adder itself stays external and is connected at the ALU top level.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> all outputs 0; assert rst_n during HI -> IDLE immediately, no resp_valid afterwards.
- req0 ADD a=25, b=40 -> req_ready[0] pulse; 2 cycles later resp_valid=1, result=1, cout=1, ovf=0, id=0.
- req1 ADD a=20, b=20 -> result=40 (0x28), cout=0, ovf=1; and req1 SUB a=5, b=9 -> result=0x3C, cout=0, ovf=0.
- 12-bit ops:
  - req0 SUB12 a=0x100, b=0x001 -> LO pass add_a=0, add_b=0x3E, add_cin=1; result=0x0FF, cout=1, ovf=0 at 3-cycle latency.
  - ADD12 0xFFF + 0x001 -> result=0x000, cout=1, ovf=0.
- Both req_valid high continuously after reset -> grants alternate 0,1,0,1; resp_id matches each grant order.
- resp_ready held low 5 cycles in DONE -> resp_* stable, req_ready stays 0; resp_ready=1 -> IDLE next cycle, then the next grant.
